fb_swap_controller: RTL and testbench

- Sequences the double-buffered 16-bit framebuffer pair that sits between the ray-cast pixel stream and the video scan-out.
- Owns the front/back buffer selection and the back-buffer write port: an optional clear sweep, ray-pixel writes, and the swap.
- Swaps only at a video frame boundary, and only once the back frame is complete.
- Throttles the ray pipeline with ready/valid and reports frame statistics.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_clear_sweeper.sv | 63 ++++++
 rtl/fb_swap_controller.sv | 174 +++++++++++++++++
 tb/tb_fb_swap_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the double-buffered framebuffer controller.
package fb_pkg;

  localparam int unsigned PIXEL_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH  = 16;
  localparam int unsigned DEPTH       = 320 * 180;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    CLEAR,
    RENDER,
    WAIT_SWAP
  } fb_state_t;

  typedef enum logic {
    SW_IDLE,
    SW_RUN
  } sweep_state_t;

endpackage

// File: rtl/fb_clear_sweeper.sv
// Address generator for the back-buffer clear sweep: one address per cycle, done on the last.
module fb_clear_sweeper
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter bit          CLEAR_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_in,
  output logic                  valid_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  done_out
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  sweep_state_t          sw_state_q, sw_state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_state_q <= SW_IDLE;
      cnt_q      <= '0;
    end else begin
      sw_state_q <= sw_state_d;
      cnt_q      <= cnt_d;
    end
  end

  // The idle cycle on entry keeps writes off during reset and absorbs a pending ray write.
  always_comb begin
    sw_state_d = sw_state_q;
    cnt_d      = cnt_q;
    valid_out  = 1'b0;
    done_out   = 1'b0;
    addr_out   = cnt_q;
    case (sw_state_q)
      SW_IDLE: begin
        if (en_in) begin
          if (CLEAR_EN) begin
            sw_state_d = SW_RUN;
          end else begin
            done_out = 1'b1;
          end
        end
      end
      SW_RUN: begin
        valid_out = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          done_out   = 1'b1;
          cnt_d      = '0;
          sw_state_d = SW_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: sw_state_d = SW_IDLE;
    endcase
  end

endmodule

// File: rtl/fb_swap_controller.sv
// Framebuffer pair sequencer: back-buffer clear, ray-pixel writes, and frame-boundary swap.
module fb_swap_controller
  import fb_pkg::*;
#(
  parameter int unsigned            PIXEL_WIDTH   = 16,
  parameter int unsigned            SCREEN_WIDTH  = 320,
  parameter int unsigned            SCREEN_HEIGHT = 180,
  parameter int unsigned            ADDR_WIDTH    = 16,
  parameter bit                     CLEAR_EN      = 1'b1,
  parameter logic [PIXEL_WIDTH-1:0] CLEAR_COLOR   = '0
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  input  logic                   ray_valid_in,
  output logic                   ray_ready_out,
  input  logic [ADDR_WIDTH-1:0]  ray_address_in,
  input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
  input  logic                   ray_last_in,
  input  logic                   video_last_pixel_in,
  output logic                   frame_start_out,
  output logic                   front_sel_out,
  output logic                   swap_out,
  output logic                   fb1_we_out,
  output logic                   fb2_we_out,
  output logic [ADDR_WIDTH-1:0]  fb_wr_addr_out,
  output logic [PIXEL_WIDTH-1:0] fb_wr_data_out,
  output logic [15:0]            frame_count_out,
  output logic [15:0]            repeat_count_out,
  output logic                   addr_err_out
);

  localparam int unsigned           DEPTH   = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  fb_state_t              state_q, state_d;
  logic                   front_sel_q, front_sel_d;
  logic                   swap_q, swap_d;
  logic                   frame_start_q, frame_start_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [15:0]            repeat_count_q, repeat_count_d;
  logic                   addr_err_q, addr_err_d;
  logic                   wr_valid_q, wr_valid_d;
  logic                   wr_fb1_q, wr_fb1_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [PIXEL_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                   ray_accept;
  logic                   addr_ok;
  logic                   sweep_valid;
  logic                   sweep_done;
  logic [ADDR_WIDTH-1:0]  sweep_addr;

  fb_clear_sweeper #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CLEAR_EN   (CLEAR_EN)
  ) u_sweeper (
    .clk       (pixel_clk_in),
    .rst_n     (rst_n_in),
    .en_in     (state_q == CLEAR),
    .valid_out (sweep_valid),
    .addr_out  (sweep_addr),
    .done_out  (sweep_done)
  );

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= CLEAR;
      front_sel_q    <= 1'b0;
      swap_q         <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_count_q  <= '0;
      repeat_count_q <= '0;
      addr_err_q     <= 1'b0;
      wr_valid_q     <= 1'b0;
      wr_fb1_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      front_sel_q    <= front_sel_d;
      swap_q         <= swap_d;
      frame_start_q  <= frame_start_d;
      frame_count_q  <= frame_count_d;
      repeat_count_q <= repeat_count_d;
      addr_err_q     <= addr_err_d;
      wr_valid_q     <= wr_valid_d;
      wr_fb1_q       <= wr_fb1_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    front_sel_d    = front_sel_q;
    swap_d         = 1'b0;
    frame_count_d  = frame_count_q;
    repeat_count_d = repeat_count_q;
    addr_err_d     = addr_err_q;
    wr_valid_d     = 1'b0;
    wr_fb1_d       = wr_fb1_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    ray_accept     = (state_q == RENDER) && ray_valid_in;
    addr_ok        = {1'b0, ray_address_in} < DEPTH_W;

    case (state_q)
      CLEAR: begin
        if (sweep_done) state_d = RENDER;
      end
      RENDER: begin
        if (ray_accept) begin
          if (addr_ok) begin
            // Target is fixed here so a same-cycle swap cannot redirect this write.
            wr_valid_d = 1'b1;
            wr_fb1_d   = front_sel_q;
            wr_addr_d  = ray_address_in;
            wr_data_d  = ray_pixel_in;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        if (ray_accept && ray_last_in) begin
          if (video_last_pixel_in) begin
            front_sel_d   = !front_sel_q;
            swap_d        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = CLEAR;
          end else begin
            state_d = WAIT_SWAP;
          end
        end else if (video_last_pixel_in) begin
          repeat_count_d = repeat_count_q + 16'd1;
        end
      end
      WAIT_SWAP: begin
        if (video_last_pixel_in) begin
          front_sel_d   = !front_sel_q;
          swap_d        = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase

    frame_start_d = (state_d == RENDER) && (state_q != RENDER);
  end

  // Ray write and clear sweep never overlap: the sweeper idles on the cycle a ray write drains.
  always_comb begin
    if (wr_valid_q) begin
      fb1_we_out     = wr_fb1_q;
      fb2_we_out     = !wr_fb1_q;
      fb_wr_addr_out = wr_addr_q;
      fb_wr_data_out = wr_data_q;
    end else begin
      fb1_we_out     = sweep_valid && front_sel_q;
      fb2_we_out     = sweep_valid && !front_sel_q;
      fb_wr_addr_out = sweep_valid ? sweep_addr : '0;
      fb_wr_data_out = sweep_valid ? CLEAR_COLOR : '0;
    end
  end

  assign ray_ready_out    = (state_q == RENDER);
  assign frame_start_out  = frame_start_q;
  assign front_sel_out    = front_sel_q;
  assign swap_out         = swap_q;
  assign frame_count_out  = frame_count_q;
  assign repeat_count_out = repeat_count_q;
  assign addr_err_out     = addr_err_q;

endmodule

// File: tb/tb_fb_swap_controller.sv
// Directed bench for fb_swap_controller on an 8x4 screen with hand-computed expectations.
module tb_fb_swap_controller;

  localparam int unsigned PW = 16;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ray_valid = 1'b0;
  logic          ray_ready;
  logic [AW-1:0] ray_addr = '0;
  logic [PW-1:0] ray_pixel = '0;
  logic          ray_last = 1'b0;
  logic          video_last = 1'b0;
  logic          frame_start;
  logic          front_sel;
  logic          swap;
  logic          fb1_we;
  logic          fb2_we;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic [15:0]   frame_count;
  logic [15:0]   repeat_count;
  logic          addr_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fb_swap_controller #(
    .PIXEL_WIDTH   (16),
    .SCREEN_WIDTH  (8),
    .SCREEN_HEIGHT (4),
    .ADDR_WIDTH    (AW),
    .CLEAR_EN      (1'b1),
    .CLEAR_COLOR   (16'h0000)
  ) dut (
    .pixel_clk_in        (clk),
    .rst_n_in            (rst_n),
    .ray_valid_in        (ray_valid),
    .ray_ready_out       (ray_ready),
    .ray_address_in      (ray_addr),
    .ray_pixel_in        (ray_pixel),
    .ray_last_in         (ray_last),
    .video_last_pixel_in (video_last),
    .frame_start_out     (frame_start),
    .front_sel_out       (front_sel),
    .swap_out            (swap),
    .fb1_we_out          (fb1_we),
    .fb2_we_out          (fb2_we),
    .fb_wr_addr_out      (wr_addr),
    .fb_wr_data_out      (wr_data),
    .frame_count_out     (frame_count),
    .repeat_count_out    (repeat_count),
    .addr_err_out        (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic e1, input logic e2,
                        input logic [AW-1:0] ea, input logic [PW-1:0] ed);
    chk({tag, ".fb1_we"}, 32'(fb1_we), 32'(e1));
    chk({tag, ".fb2_we"}, 32'(fb2_we), 32'(e2));
    if (e1 || e2) begin
      chk({tag, ".addr"}, 32'(wr_addr), 32'(ea));
      chk({tag, ".data"}, 32'(wr_data), 32'(ed));
    end
  endtask

  // Expects 32 clear writes into the given buffer, then the frame_start cycle.
  task automatic sweep_check(input string tag, input logic to_fb1);
    for (int k = 0; k < 32; k++) begin
      step();
      chk_wr(tag, to_fb1, !to_fb1, AW'(k), 16'h0000);
      chk({tag, ".ready"}, 32'(ray_ready), 32'd0);
      chk({tag, ".fstart"}, 32'(frame_start), 32'd0);
    end
    step();
    chk({tag, ".fstart_end"}, 32'(frame_start), 32'd1);
    chk({tag, ".ready_end"}, 32'(ray_ready), 32'd1);
    chk_wr({tag, ".nowr_end"}, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #2;
    chk("rst.ready", 32'(ray_ready), 32'd0);
    chk("rst.we", 32'({fb1_we, fb2_we}), 32'd0);
    chk("rst.front", 32'(front_sel), 32'd0);
    chk("rst.fcnt", 32'(frame_count), 32'd0);
    chk("rst.err", 32'(addr_err), 32'd0);
    step();
    step();
    chk("rst.hold_we", 32'({fb1_we, fb2_we, swap, frame_start}), 32'd0);
    rst_n = 1'b1;

    // Initial clear of FB2, then frame_start
    sweep_check("clr0", 1'b0);
    chk("clr0.front", 32'(front_sel), 32'd0);

    // Full frame of 32 beats into FB2
    for (int i = 0; i < 32; i++) begin
      ray_valid = 1'b1;
      ray_addr  = AW'(i);
      ray_pixel = 16'hF800 + 16'(i);
      ray_last  = (i == 31);
      chk("rend.ready", 32'(ray_ready), 32'd1);
      chk("rend.fstart", 32'(frame_start), (i == 0) ? 32'd1 : 32'd0);
      if (i == 0) chk_wr("rend.first", 1'b0, 1'b0, '0, '0);
      else chk_wr("rend.wr", 1'b0, 1'b1, AW'(i - 1), 16'hF800 + 16'(i - 1));
      step();
    end
    ray_valid = 1'b0;
    ray_last  = 1'b0;
    chk_wr("rend.last_wr", 1'b0, 1'b1, 8'd31, 16'hF81F);
    chk("wait.ready", 32'(ray_ready), 32'd0);
    step();
    chk("wait.ready2", 32'(ray_ready), 32'd0);
    chk("wait.swap", 32'(swap), 32'd0);
    video_last = 1'b1;
    step();
    video_last = 1'b0;
    chk("swap1.pulse", 32'(swap), 32'd1);
    chk("swap1.front", 32'(front_sel), 32'd1);
    chk("swap1.fcnt", 32'(frame_count), 32'd1);
    chk_wr("swap1.nowr", 1'b0, 1'b0, '0, '0);
    sweep_check("clr1", 1'b1);

    // Two video frames without a finished back frame
    video_last = 1'b1;
    step();
    video_last = 1'b0;
    chk("rep.swap", 32'(swap), 32'd0);
    step();
    video_last = 1'b1;
    step();
    video_last = 1'b0;
    chk("rep.count", 32'(repeat_count), 32'd2);
    chk("rep.front", 32'(front_sel), 32'd1);
    chk("rep.fcnt", 32'(frame_count), 32'd1);
    chk("rep.ready", 32'(ray_ready), 32'd1);

    // Out-of-range address
    ray_valid = 1'b1;
    ray_addr  = 8'd40;
    ray_pixel = 16'h1234;
    step();
    ray_valid = 1'b0;
    chk_wr("oor.nowr", 1'b0, 1'b0, '0, '0);
    chk("oor.err", 32'(addr_err), 32'd1);
    chk("oor.ready", 32'(ray_ready), 32'd1);

    // Last beat coincident with video_last: swap, tear write into old back (FB1)
    ray_valid  = 1'b1;
    ray_addr   = 8'd5;
    ray_pixel  = 16'hABCD;
    ray_last   = 1'b1;
    video_last = 1'b1;
    step();
    ray_valid  = 1'b0;
    ray_last   = 1'b0;
    video_last = 1'b0;
    chk("sim.swap", 32'(swap), 32'd1);
    chk("sim.front", 32'(front_sel), 32'd0);
    chk("sim.fcnt", 32'(frame_count), 32'd2);
    chk("sim.rcnt", 32'(repeat_count), 32'd2);
    chk("sim.ready", 32'(ray_ready), 32'd0);
    chk_wr("sim.tear", 1'b1, 1'b0, 8'd5, 16'hABCD);
    sweep_check("clr2", 1'b0);
    chk("clr2.err", 32'(addr_err), 32'd1);

    // Short frame; WAIT_SWAP must not accept
    ray_valid = 1'b1;
    ray_addr  = 8'd2;
    ray_pixel = 16'h55AA;
    ray_last  = 1'b1;
    step();
    ray_addr  = 8'd9;
    ray_last  = 1'b0;
    chk_wr("f3.wr", 1'b0, 1'b1, 8'd2, 16'h55AA);
    chk("f3.ready", 32'(ray_ready), 32'd0);
    step();
    chk_wr("f3.noacc", 1'b0, 1'b0, '0, '0);
    video_last = 1'b1;
    step();
    video_last = 1'b0;
    ray_valid  = 1'b0;
    chk("f3.swap", 32'(swap), 32'd1);
    chk("f3.front", 32'(front_sel), 32'd1);
    chk("f3.fcnt", 32'(frame_count), 32'd3);
    chk("f3.err", 32'(addr_err), 32'd1);
    sweep_check("clr3", 1'b1);

    // Reset mid-render with valid high
    ray_valid = 1'b1;
    ray_addr  = 8'd3;
    ray_pixel = 16'h7777;
    step();
    chk_wr("mid.wr", 1'b1, 1'b0, 8'd3, 16'h7777);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.we", 32'({fb1_we, fb2_we}), 32'd0);
    chk("arst.addr", 32'(wr_addr), 32'd0);
    chk("arst.data", 32'(wr_data), 32'd0);
    chk("arst.ready", 32'(ray_ready), 32'd0);
    chk("arst.front", 32'(front_sel), 32'd0);
    chk("arst.fcnt", 32'(frame_count), 32'd0);
    chk("arst.rcnt", 32'(repeat_count), 32'd0);
    chk("arst.err", 32'(addr_err), 32'd0);
    step();
    step();
    chk("arst.hold", 32'({fb1_we, fb2_we, ray_ready}), 32'd0);
    ray_valid = 1'b0;
    rst_n     = 1'b1;
    sweep_check("clr4", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
